mem_arbiter: RTL

- Sits directly downstream of the cache-side bus (icache + dcache request/wait ports) and upstream of the single-ported RAM.
- Grants one cache at a time and drives RAM read/write strobes. Returns wait/load to the granted cache.
- Adds fairness (instruction fetch is never starved by back-to-back data traffic) and a per-transaction timeout with a sticky error flag.
- Single-core build: coherence inputs of the dcache are tied off here.

---
 rtl/mem_arbiter.sv | 83 ++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the single-ported RAM to icache or dcache with alternating fairness,
// a per-grant timeout that returns BADWORD, and a sticky error flag.
module mem_arbiter #(
    parameter int          TIMEOUT = 64,
    parameter logic [31:0] BADWORD = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ccwait,
    output logic        ccinv,
    output logic [31:0] ccsnoopaddr,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        err
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, DGNT, IGNT} state_t;
    state_t        state;
    logic          last_d;
    logic [CW-1:0] cnt;
    logic          dgnt, ignt, req, acc, tout, done;
    // Outputs are forced to their reset values while RST is held.
    assign dgnt = (state == DGNT) & ~RST;
    assign ignt = (state == IGNT) & ~RST;
    assign req  = (state == DGNT) ? (dREN | dWEN) : iREN;
    assign acc  = ramstate == 2'd2;
    assign tout = ~acc & (cnt == CW'(TIMEOUT - 1));
    assign done = (dgnt | ignt) & req & (acc | tout);
    assign ramREN   = dgnt ? (dREN & ~dWEN) : (ignt & iREN);
    assign ramWEN   = dgnt & dWEN;
    assign ramaddr  = dgnt ? daddr : ignt ? iaddr : '0;
    assign ramstore = dgnt ? dstore : '0;
    assign dwait    = ~(dgnt & done);
    assign iwait    = ~(ignt & done);
    assign dload    = dgnt ? (tout ? BADWORD : ramload) : '0;
    assign iload    = ignt ? (tout ? BADWORD : ramload) : '0;
    assign ccwait      = 1'b0;
    assign ccinv       = 1'b0;
    assign ccsnoopaddr = '0;
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            last_d <= 1'b0;
            cnt    <= '0;
            err    <= 1'b0;
        end else if (state == IDLE) begin
            cnt <= '0;
            if ((dREN | dWEN) & ~(iREN & last_d))
                state <= DGNT;
            else if (iREN)
                state <= IGNT;
        end else begin
            if (ramstate == 2'd3)
                err <= 1'b1;
            if (~req) begin
                state <= IDLE;
                cnt   <= '0;
            end else if (acc | tout) begin
                state  <= IDLE;
                cnt    <= '0;
                last_d <= (state == DGNT);
                if (tout)
                    err <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule
